// File: rtl/iter_div_unit.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor bypasses the iteration loop.
module iter_div_unit #(
    parameter int XLEN           = 32,
    parameter int ITER_CNT_WIDTH = 6,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [XLEN-1:0]      req_dividend,
    input  logic [XLEN-1:0]      req_divisor,
    input  logic                 req_signed,
    input  logic                 req_rem,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_data,
    output logic [TAG_WIDTH-1:0] resp_tag
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [ITER_CNT_WIDTH-1:0] LAST_ITER = ITER_CNT_WIDTH'(XLEN - 1);

    state_t                state_q, state_d;
    logic [ITER_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]       rem_q, rem_d;
    logic [XLEN-1:0]       quo_q, quo_d;
    logic [XLEN-1:0]       dvs_q, dvs_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  rem_sel_q, rem_sel_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]       resp_data_q, resp_data_d;
    logic [TAG_WIDTH-1:0]  resp_tag_q, resp_tag_d;

    logic                  accept;
    logic                  a_neg, b_neg, div_zero;
    logic [XLEN:0]         shifted, diff;
    logic [XLEN-1:0]       step_rem, step_quo, fix_quo, fix_rem, result;

    assign req_ready  = req_ready_q & ~flush;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;

    assign accept   = req_valid & req_ready;
    assign a_neg    = req_signed & req_dividend[XLEN-1];
    assign b_neg    = req_signed & req_divisor[XLEN-1];
    assign div_zero = (req_divisor == '0);

    // One restoring step: a set carry-out means the trial difference went negative.
    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign step_rem = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign step_quo = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign fix_quo  = neg_quo_q ? -step_quo : step_quo;
    assign fix_rem  = neg_rem_q ? -step_rem : step_rem;
    assign result   = rem_sel_q ? fix_rem : fix_quo;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        tag_d        = tag_q;
        rem_sel_d    = rem_sel_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tag_d       = req_tag;
                    rem_sel_d   = req_rem;
                    dvs_d       = b_neg ? -req_divisor : req_divisor;
                    // A zero divisor keeps the raw dividend so the loop returns it unchanged.
                    quo_d       = (a_neg && !div_zero) ? -req_dividend : req_dividend;
                    rem_d       = '0;
                    neg_quo_d   = (a_neg ^ b_neg) & ~div_zero;
                    neg_rem_d   = a_neg & ~div_zero;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
`ifdef DIV_ZERO_FAST_EN
                    if (div_zero) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = req_rem ? req_dividend : '1;
                        resp_tag_d   = req_tag;
                    end else begin
                        state_d = CALC;
                    end
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = (cnt_q == LAST_ITER) ? '0 : cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = result;
                    resp_tag_d   = tag_q;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase

        if (flush) begin
            state_d      = IDLE;
            cnt_d        = '0;
            resp_valid_d = 1'b0;
            req_ready_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            tag_q        <= '0;
            rem_sel_q    <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvs_q        <= dvs_d;
            tag_q        <= tag_d;
            rem_sel_q    <= rem_sel_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
        end
    end
endmodule

// File: tb/tb_iter_div_unit.sv
// Directed scoreboard bench for iter_div_unit: results, tags, latency, backpressure, flush.
module tb_iter_div_unit;
    logic        clk = 1'b0;
    logic        reset, flush, req_valid, req_ready;
    logic [31:0] req_dividend, req_divisor;
    logic        req_signed, req_rem;
    logic [3:0]  req_tag;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [3:0]  resp_tag;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 33;
`endif

    iter_div_unit dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_signed   (req_signed),
        .req_rem      (req_rem),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_tag     (resp_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for the handshake edge, push the expected result.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic r, input logic [3:0] t, input logic [31:0] exp);
        int w;
        @(negedge clk);
        req_dividend = a;
        req_divisor  = b;
        req_signed   = s;
        req_rem      = r;
        req_tag      = t;
        req_valid    = 1'b1;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        sb.push_back('{exp, t});
        $display("req  a=%h b=%h signed=%0d rem=%0d tag=%0d exp=%h", a, b, s, r, t, exp);
    endtask

    // Wait for the response, compare against the scoreboard, optionally stall, then accept.
    task automatic get_resp(input string name, input int exp_lat, input int hold);
        int   lat;
        exp_t e;
        lat = 1;
        while (1) begin
            @(negedge clk);
            if (resp_valid || lat > 100) break;
            @(posedge clk);
            lat++;
        end
        e = sb.pop_front();
        $display("resp %s data=%h tag=%0d latency=%0d", name, resp_data, resp_tag, lat);
        chk({name, "_data"}, resp_data, e.data);
        chk({name, "_tag"}, {28'd0, resp_tag}, {28'd0, e.tag});
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, "_hold_data"}, resp_data, e.data);
            chk({name, "_hold_tag"}, {28'd0, resp_tag}, {28'd0, e.tag});
            chk({name, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({name, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({name, "_after_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({name, "_after_req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int seen;
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_dividend = '0; req_divisor = '0; req_signed = 1'b0; req_rem = 1'b0; req_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_tag", {28'd0, resp_tag}, 32'd0);
        reset = 1'b0;

        send(32'd100, 32'd7, 1'b0, 1'b0, 4'd3, 32'd14);
        get_resp("divu_100_7", 33, 0);
        send(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 4'd1, 32'hFFFFFFFF);
        get_resp("rem_m7_2", 33, 0);
        send(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 4'd2, 32'hFFFFFFFD);
        get_resp("div_m7_2", 33, 0);
        send(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 4'd4, 32'hFFFFFFFD);
        get_resp("div_7_m2", 33, 0);
        send(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 4'd6, 32'd1);
        get_resp("rem_7_m2", 33, 0);
        send(32'hFFFFFFF6, 32'd0, 1'b1, 1'b0, 4'd8, 32'hFFFFFFFF);
        get_resp("div_by_zero", DZ_LAT, 0);
        send(32'hFFFFFFF6, 32'd0, 1'b1, 1'b1, 4'd9, 32'hFFFFFFF6);
        get_resp("rem_by_zero", DZ_LAT, 0);
        send(32'hFFFFFFF6, 32'd0, 1'b0, 1'b0, 4'd10, 32'hFFFFFFFF);
        get_resp("divu_by_zero", DZ_LAT, 0);
        send(32'hFFFFFFF6, 32'd0, 1'b0, 1'b1, 4'd11, 32'hFFFFFFF6);
        get_resp("remu_by_zero", DZ_LAT, 0);
        send(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 4'd12, 32'h80000000);
        get_resp("div_ovf", 33, 0);
        send(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 4'd13, 32'd0);
        get_resp("rem_ovf", 33, 0);

        // Backpressure then back-to-back request.
        send(32'd100, 32'd7, 1'b0, 1'b1, 4'd5, 32'd2);
        get_resp("remu_stall", 33, 5);
        send(32'd50, 32'd5, 1'b0, 1'b0, 4'd14, 32'd10);
        get_resp("divu_50_5", 33, 0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 1000);
            send(ra, rb, 1'b0, i[0], 4'(i), i[0] ? ra % rb : ra / rb);
            get_resp("rand_unsigned", 33, 0);
        end

        // Flush at iteration 10; a request offered with flush must be refused.
        send(32'd100, 32'd7, 1'b0, 1'b0, 4'd3, 32'd14);
        void'(sb.pop_back());
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        req_dividend = 32'd9; req_divisor = 32'd3; req_signed = 1'b0; req_rem = 1'b0;
        req_tag = 4'd7; req_valid = 1'b1;
        #1 chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("flush_req_ready_after", {31'd0, req_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("flush_no_resp", 32'(seen), 32'd0);
        send(32'd9, 32'd3, 1'b0, 1'b0, 4'd15, 32'd3);
        get_resp("divu_9_3", 33, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
